// File: rtl/sram_if_pkg.sv
// Shared defaults and request type for the fakeram7 initiator-side adapter.
package sram_if_pkg;

    localparam int SRAM_BITS       = 32;
    localparam int SRAM_ADDR_WIDTH = 8;
    localparam int SRAM_RSP_DEPTH  = 2;

    typedef struct packed {
        logic                       we;
        logic [SRAM_ADDR_WIDTH-1:0] addr;
        logic [SRAM_BITS-1:0]       wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response FIFO: power-of-two depth, wrapping pointers, explicit count.
module sram_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             do_pop;

    assign do_pop = pop_i & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_i);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(push_i) - CW'(do_pop);
        last_d   = do_pop ? mem_q[rd_ptr_q] : last_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // When empty, present the last popped word so the output never shows unwritten storage.
    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : last_q;
    assign count_o = count_q;

endmodule

// File: rtl/sram_req_adapter.sv
// Turns a valid/ready request stream into single-cycle fakeram7 accesses and
// returns read data through a credit-limited response FIFO.
module sram_req_adapter
    import sram_if_pkg::*;
#(
    parameter int BITS       = SRAM_BITS,
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int RSP_DEPTH  = SRAM_RSP_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BITS-1:0]       req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BITS-1:0]       rsp_rdata,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [BITS-1:0]       sram_wd,
    input  logic [BITS-1:0]       sram_rd
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;

    logic          acc;
    logic          pop;
    logic          rd_pend_q, rd_pend_d;
    logic [CW-1:0] count;
    logic [CW-1:0] occ;

    assign acc = req_valid & req_ready;
    assign pop = rsp_valid & rsp_ready;

    // A pending read reserves a FIFO slot; a same-cycle pop frees one early.
    assign occ       = count + CW'(rd_pend_q);
    assign req_ready = ~reset & ((occ - CW'(pop)) < CW'(RSP_DEPTH));

    assign sram_ce   = acc;
    assign sram_we   = req_we & acc;
    assign sram_addr = req_addr;
    assign sram_wd   = req_wdata;

    assign rd_pend_d = acc & ~req_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
        end
    end

    sram_rsp_fifo #(
        .WIDTH (BITS),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rd_pend_q),
        .wdata_i (sram_rd),
        .pop_i   (pop),
        .rdata_o (rsp_rdata),
        .valid_o (rsp_valid),
        .count_o (count)
    );

endmodule

// File: tb/tb_sram_req_adapter.sv
// Scoreboard bench for sram_req_adapter with a write-first SRAM model that
// drives random data on rd_out whenever no read was issued.
module tb_sram_req_adapter;
    import sram_if_pkg::*;

    localparam int BITS = 32;
    localparam int AW   = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [BITS-1:0] req_wdata = '0;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [BITS-1:0] rsp_rdata;
    logic            sram_ce;
    logic            sram_we;
    logic [AW-1:0]   sram_addr;
    logic [BITS-1:0] sram_wd;
    logic [BITS-1:0] sram_rd;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int resp_cnt = 0;
    int rsp_mode = 0;

    logic [BITS-1:0] mem_m [256];
    logic [BITS-1:0] rd_m;
    logic [BITS-1:0] ref_mem [256];
    logic [BITS-1:0] exp_q [$];

    sram_req_adapter #(.BITS(BITS), .ADDR_WIDTH(AW), .RSP_DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_ce   (sram_ce),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wd   (sram_wd),
        .sram_rd   (sram_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: registered read, write-first across cycles, garbage otherwise.
    always @(posedge clk) begin
        if (sram_ce && sram_we) mem_m[sram_addr] <= sram_wd;
        if (sram_ce && !sram_we) rd_m <= mem_m[sram_addr];
        else rd_m <= $urandom;
    end
    assign sram_rd = rd_m;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic sram_req_t mk(input logic we, input logic [AW-1:0] a, input logic [BITS-1:0] d);
        sram_req_t r;
        r.we = we;
        r.addr = a;
        r.wdata = d;
        return r;
    endfunction

    task automatic send(input sram_req_t r);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = r.we;
        req_addr  = r.addr;
        req_wdata = r.wdata;
        @(negedge clk);
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk_eq("req_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Called one cycle after the read was accepted, with the FIFO empty.
    task automatic expect_lat2(input logic [BITS-1:0] exp);
        @(negedge clk);
        chk_eq("lat_n1_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk_eq("lat_n2_valid", 32'(rsp_valid), 32'd1);
        chk_eq("lat_n2_data", rsp_rdata, exp);
    endtask

    // Response-ready driver
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rsp_mode)
                0: rsp_ready = 1'b0;
                1: rsp_ready = 1'b1;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard monitor, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (req_valid && req_ready) begin
                    acc_cnt++;
                    if (req_we) ref_mem[req_addr] = req_wdata;
                    else exp_q.push_back(ref_mem[req_addr]);
                end
                if (rsp_valid && rsp_ready) begin
                    resp_cnt++;
                    if (exp_q.size() == 0) chk_eq("rsp_extra", 32'(exp_q.size()), 32'd1);
                    else chk_eq("rsp_data", rsp_rdata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int a0;
        int r0;
        bit done4;

        // Reset state, with a request offered during reset
        req_valid = 1'b1;
        req_addr  = 8'h05;
        repeat (3) @(posedge clk);
        #2;
        chk_eq("rst_req_ready", 32'(req_ready), 32'd0);
        chk_eq("rst_sram_ce", 32'(sram_ce), 32'd0);
        chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rsp_mode = 1;

        // Write then read the same address back-to-back
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk_eq("t1_wr_ce", 32'(sram_ce), 32'd1);
        chk_eq("t1_wr_we", 32'(sram_we), 32'd1);
        chk_eq("t1_wr_addr", 32'(sram_addr), 32'h10);
        chk_eq("t1_wr_wd", sram_wd, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        req_we = 1'b0;
        @(negedge clk);
        chk_eq("t1_rd_ce", 32'(sram_ce), 32'd1);
        chk_eq("t1_rd_we", 32'(sram_we), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        expect_lat2(32'hDEADBEEF);
        wait_drain(10);

        // Fill 0..7, then 8 reads at full rate
        for (int i = 0; i < 8; i++) send(mk(1'b1, AW'(i), 32'(i) * 32'h11111111));
        c0 = cyc;
        r0 = resp_cnt;
        for (int i = 0; i < 8; i++) send(mk(1'b0, AW'(i), '0));
        chk_eq("t3_read_cycles", 32'(cyc - c0), 32'd8);
        wait_drain(20);
        chk_eq("t3_resp_count", 32'(resp_cnt - r0), 32'd8);

        // Same reads with the consumer stalled
        rsp_mode = 0;
        @(posedge clk);
        #1;
        a0 = acc_cnt;
        r0 = resp_cnt;
        done4 = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(mk(1'b0, AW'(i), '0));
                done4 = 1'b1;
            end
        join_none
        repeat (10) @(negedge clk);
        chk_eq("t4_stall_accepts", 32'(acc_cnt - a0), 32'd2);
        chk_eq("t4_stall_ready", 32'(req_ready), 32'd0);
        rsp_mode = 1;
        for (int n = 0; n < 100 && !done4; n++) @(negedge clk);
        chk_eq("t4_done", 32'(done4), 32'd1);
        wait_drain(20);
        chk_eq("t4_resp_count", 32'(resp_cnt - r0), 32'd8);
        chk_eq("t4_accept_count", 32'(acc_cnt - a0), 32'd8);

        // Interleaved W/R to one address with random backpressure
        rsp_mode = 2;
        r0 = resp_cnt;
        for (int i = 0; i < 10000; i++) begin
            if (i % 2 == 0) send(mk(1'b1, 8'h20, $urandom));
            else send(mk(1'b0, 8'h20, '0));
        end
        rsp_mode = 1;
        wait_drain(100);
        chk_eq("t5_resp_count", 32'(resp_cnt - r0), 32'd5000);

        // Reset with one read pending and one response buffered
        rsp_mode = 0;
        @(posedge clk);
        #1;
        send(mk(1'b0, 8'h01, '0));
        send(mk(1'b0, 8'h02, '0));
        #1;
        chk_eq("t6_pre_rsp_valid", 32'(rsp_valid), 32'd1);
        chk_eq("t6_pre_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk_eq("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk_eq("t6_rst_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        r0 = resp_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rsp_mode = 1;
        repeat (6) @(negedge clk);
        chk_eq("t6_no_stale", 32'(resp_cnt - r0), 32'd0);
        chk_eq("t6_post_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        send(mk(1'b1, 8'h03, 32'h13579BDF));
        send(mk(1'b0, 8'h03, '0));
        expect_lat2(32'h13579BDF);
        wait_drain(10);

        // Response must come from the rd_pend sample despite changing rd_out
        rsp_mode = 0;
        send(mk(1'b1, 8'h30, 32'hCAFEF00D));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        send(mk(1'b0, 8'h30, '0));
        repeat (4) @(negedge clk);
        chk_eq("t7_hold_valid", 32'(rsp_valid), 32'd1);
        chk_eq("t7_hold_data", rsp_rdata, 32'hCAFEF00D);
        rsp_mode = 1;
        wait_drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
